controle_teclas: RTL and testbench



---
 rtl/controle_teclas_if.sv | 24 ++
 rtl/controle_teclas.sv | 186 ++++++++++++++++++
 tb/tb_controle_teclas.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/controle_teclas_if.sv
// controle_teclas_if
// Turn-command handshake between the button conditioning stage and the
// player logic.
//   cmd_valid : a command is waiting at the head of the FIFO
//   cmd_dir   : head command, 1 = clockwise, 0 = anti-clockwise
//   cmd_ready : consumer takes the head command on this clock edge
// Modports: master = producer (controle_teclas), slave = consumer.
interface controle_teclas_if;
    logic cmd_valid;
    logic cmd_dir;
    logic cmd_ready;

    modport master (
        output cmd_valid,
        output cmd_dir,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_dir,
        output cmd_ready
    );
endinterface

// File: rtl/controle_teclas.sv
// controle_teclas
// Conditions the four raw push-buttons for the light-cycle game:
// 2-flop synchronisation, optional debounce, press detection, and a small
// FIFO of turn commands popped through a valid/ready handshake.
// Ports:
//   CLOCK_50      : system clock
//   reset         : synchronous, active-high
//   KEY[3:0]      : raw active-low buttons (3 = anti-clockwise, 2 = clockwise,
//                   1 = unused, 0 = restart)
//   enable        : game running; when low no turn is queued
//   cmd           : turn-command handshake (controle_teclas_if.master)
//   restart_pulse : one-cycle pulse per accepted KEY[0] press
//   overflow      : sticky, a turn was dropped because the FIFO was full
//   fifo_count    : number of queued turn commands
// Build option: define DEBOUNCE_EN to enable the per-key debounce counters.
// Without it the synchronised value is accepted every clock.
module controle_teclas #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                          CLOCK_50,
    input  logic                          reset,
    input  logic [3:0]                    KEY,
    input  logic                          enable,
    controle_teclas_if.master             cmd,
    output logic                          restart_pulse,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [3:0]       sync1_r;
    logic [3:0]       sync2_r;
    logic [3:0]       stable_r;
    logic [3:0]       stable_d_r;
    logic [3:0]       press_s;
    logic             key1_unused_s;

    logic             mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W:0]   count_r;
    logic [PTR_W:0]   count_next_s;
    logic             valid_r;

    logic             turn_req_s;
    logic             turn_dir_s;
    logic             full_s;
    logic             pop_s;
    logic             push_s;

    // Two-flop synchroniser; released (1) is the safe reset value.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            sync1_r <= 4'hF;
            sync2_r <= 4'hF;
        end else begin
            sync1_r <= KEY;
            sync2_r <= sync1_r;
        end
    end

`ifdef DEBOUNCE_EN
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] deb_cnt_r [4];

    // Debounce: a key must differ from its accepted value for
    // DEBOUNCE_CYCLES consecutive clocks before the new value is taken.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                deb_cnt_r[i] <= {CNT_W{1'b0}};
                stable_r[i]  <= 1'b1;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (sync2_r[i] == stable_r[i]) begin
                    deb_cnt_r[i] <= {CNT_W{1'b0}};
                end else if (deb_cnt_r[i] == CNT_MAX) begin
                    stable_r[i]  <= sync2_r[i];
                    deb_cnt_r[i] <= {CNT_W{1'b0}};
                end else begin
                    deb_cnt_r[i] <= deb_cnt_r[i] + CNT_W'(1);
                end
            end
        end
    end
`else
    localparam int debounce_cycles_unused = DEBOUNCE_CYCLES;

    // No debounce: accept the synchronised value every clock.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            stable_r <= 4'hF;
        end else begin
            stable_r <= sync2_r;
        end
    end
`endif

    // Delayed copy of the accepted key state for falling-edge detection.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            stable_d_r <= 4'hF;
        end else begin
            stable_d_r <= stable_r;
        end
    end

    // A press is a 1 -> 0 transition of the accepted (active-low) value.
    assign press_s       = stable_d_r & ~stable_r;
    assign key1_unused_s = press_s[1];

    // Turn request: exactly one of the two turn keys, game enabled, and not
    // masked by a restart in the same cycle. Both keys together cancel.
    always_comb begin
        turn_req_s = 1'b0;
        turn_dir_s = 1'b0;
        if (enable && !press_s[0] && (press_s[3] ^ press_s[2])) begin
            turn_req_s = 1'b1;
            turn_dir_s = press_s[2];
        end else begin
            turn_req_s = 1'b0;
            turn_dir_s = 1'b0;
        end
    end

    assign full_s = (count_r == (PTR_W+1)'(FIFO_DEPTH));
    assign pop_s  = valid_r & cmd.cmd_ready;
    // A pop on the same edge frees the slot, so a full FIFO still accepts.
    assign push_s = turn_req_s & (~full_s | pop_s);

    // Next occupancy from the push/pop combination.
    always_comb begin
        count_next_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + (PTR_W+1)'(1);
            2'b01:   count_next_s = count_r - (PTR_W+1)'(1);
            default: count_next_s = count_r;
        endcase
    end

    // FIFO state, restart pulse and sticky overflow. Restart flushes the
    // queue and voids any pop on the same edge; overflow survives restart.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= 1'b0;
            end
            wr_ptr_r      <= {PTR_W{1'b0}};
            rd_ptr_r      <= {PTR_W{1'b0}};
            count_r       <= {(PTR_W+1){1'b0}};
            valid_r       <= 1'b0;
            restart_pulse <= 1'b0;
            overflow      <= 1'b0;
        end else if (press_s[0]) begin
            wr_ptr_r      <= {PTR_W{1'b0}};
            rd_ptr_r      <= {PTR_W{1'b0}};
            count_r       <= {(PTR_W+1){1'b0}};
            valid_r       <= 1'b0;
            restart_pulse <= 1'b1;
        end else begin
            restart_pulse <= 1'b0;
            if (push_s) begin
                mem_r[wr_ptr_r] <= turn_dir_s;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            if (turn_req_s && full_s && !pop_s) begin
                overflow <= 1'b1;
            end
            count_r <= count_next_s;
            valid_r <= (count_next_s != {(PTR_W+1){1'b0}});
        end
    end

    assign cmd.cmd_valid = valid_r;
    assign cmd.cmd_dir   = mem_r[rd_ptr_r];
    assign fifo_count    = count_r;

endmodule

// File: tb/tb_controle_teclas.sv
module tb_controle_teclas;
    localparam int DEB   = 4;
    localparam int DEPTH = 4;
`ifdef DEBOUNCE_EN
    localparam int LAT = DEB + 2;
`else
    localparam int LAT = 3;
`endif
    localparam int HOLD   = 12;
    localparam int SETTLE = 12;

    logic       CLOCK_50 = 1'b0;
    logic       reset;
    logic [3:0] KEY;
    logic       enable;
    logic       restart_pulse;
    logic       overflow;
    logic [2:0] fifo_count;

    controle_teclas_if cmd_if();

    controle_teclas #(
        .DEBOUNCE_CYCLES(DEB),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .CLOCK_50(CLOCK_50),
        .reset(reset),
        .KEY(KEY),
        .enable(enable),
        .cmd(cmd_if),
        .restart_pulse(restart_pulse),
        .overflow(overflow),
        .fifo_count(fifo_count)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    int checks = 0;
    int errors = 0;
    int pulses_seen = 0;
    bit exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: compare each popped command against the scoreboard queue.
    always @(negedge CLOCK_50) begin
        if (!reset && restart_pulse) pulses_seen++;
        if (!reset && cmd_if.cmd_valid && cmd_if.cmd_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_unexpected: got dir %0d, expected no command", cmd_if.cmd_dir);
            end else begin
                check("pop_dir", cmd_if.cmd_dir, exp_q.pop_front());
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    task automatic press_turn(input logic [3:0] val, input bit pushes, input bit dir);
        if (pushes) exp_q.push_back(dir);
        KEY = val;
        step(HOLD);
        KEY = 4'hF;
        step(SETTLE);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        KEY = 4'hF;
        enable = 1'b1;
        cmd_if.cmd_ready = 1'b0;
        step(3);
        check("rst_valid", cmd_if.cmd_valid, 0);
        check("rst_count", fifo_count, 0);
        check("rst_overflow", overflow, 0);
        check("rst_restart", restart_pulse, 0);
        check("rst_dir", cmd_if.cmd_dir, 0);
        reset = 1'b0;
        step(2);

        // Clean clockwise press latency
        exp_q.push_back(1'b1);
        KEY = 4'b1011;
        step(LAT);
        check("lat_early_valid", cmd_if.cmd_valid, 0);
        step(1);
        check("lat_valid", cmd_if.cmd_valid, 1);
        check("lat_dir", cmd_if.cmd_dir, 1);
        check("lat_count", fifo_count, 1);
        step(20 - LAT - 1);
        KEY = 4'hF;
        step(SETTLE);
        check("release_no_cmd", fifo_count, 1);

`ifdef DEBOUNCE_EN
        for (int i = 0; i < 4; i++) begin
            KEY = 4'b0111;
            step(3);
            KEY = 4'hF;
            step(3);
        end
        check("bounce_reject", fifo_count, 1);
`endif
        press_turn(4'b0111, 1'b1, 1'b0);
        check("acw_count", fifo_count, 2);
        check("head_kept", cmd_if.cmd_dir, 1);

        // Fill and overflow
        press_turn(4'b1011, 1'b1, 1'b1);
        press_turn(4'b1011, 1'b1, 1'b1);
        check("full_count", fifo_count, 4);
        check("no_overflow_yet", overflow, 0);
        press_turn(4'b1011, 1'b0, 1'b0);
        check("ovf_count", fifo_count, 4);
        check("ovf_set", overflow, 1);

        // Push into full FIFO on the same edge as a pop
        exp_q.push_back(1'b1);
        KEY = 4'b1011;
        step(LAT);
        cmd_if.cmd_ready = 1'b1;
        step(1);
        cmd_if.cmd_ready = 1'b0;
        check("full_push_pop_count", fifo_count, 4);
        check("full_push_pop_ovf", overflow, 1);
        KEY = 4'hF;
        step(SETTLE);

        // Drain back-to-back
        cmd_if.cmd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1);
            check("drain_count", fifo_count, 3 - i);
        end
        cmd_if.cmd_ready = 1'b0;
        check("drain_valid", cmd_if.cmd_valid, 0);
        check("drain_sb_empty", exp_q.size(), 0);

        // Ordering across pointer wrap
        for (int r = 0; r < 2; r++) begin
            press_turn(4'b1011, 1'b1, 1'b1);
            press_turn(4'b0111, 1'b1, 1'b0);
            press_turn(4'b1011, 1'b1, 1'b1);
            check("order_count", fifo_count, 3);
            cmd_if.cmd_ready = 1'b1;
            for (int i = 0; i < 3; i++) begin
                step(1);
                check("order_pop_count", fifo_count, 2 - i);
            end
            cmd_if.cmd_ready = 1'b0;
        end

        // Both turn keys together cancel
        press_turn(4'b0011, 1'b0, 1'b0);
        check("both_keys_count", fifo_count, 0);
        check("both_keys_ovf", overflow, 1);

        // Restart flushes queue, keeps overflow
        press_turn(4'b1011, 1'b1, 1'b1);
        press_turn(4'b1011, 1'b1, 1'b1);
        press_turn(4'b0111, 1'b1, 1'b0);
        check("pre_restart_count", fifo_count, 3);
        KEY = 4'b1110;
        step(LAT);
        check("restart_early", restart_pulse, 0);
        check("restart_early_count", fifo_count, 3);
        step(1);
        check("restart_pulse", restart_pulse, 1);
        check("restart_count", fifo_count, 0);
        check("restart_valid", cmd_if.cmd_valid, 0);
        check("restart_ovf_kept", overflow, 1);
        exp_q.delete();
        step(1);
        check("restart_one_cycle", restart_pulse, 0);
        KEY = 4'hF;
        step(SETTLE);
        check("restart_pulse_total", pulses_seen, 1);

        // enable low blocks pushes
        enable = 1'b0;
        press_turn(4'b1011, 1'b0, 1'b0);
        check("disabled_count", fifo_count, 0);
        enable = 1'b1;

        // Reset mid-operation with a press pending
        press_turn(4'b1011, 1'b1, 1'b1);
        press_turn(4'b0111, 1'b1, 1'b0);
        check("pre_reset_count", fifo_count, 2);
        KEY = 4'b1011;
        step(LAT);
        reset = 1'b1;
        KEY = 4'hF;
        step(1);
        check("mid_rst_valid", cmd_if.cmd_valid, 0);
        check("mid_rst_count", fifo_count, 0);
        check("mid_rst_overflow", overflow, 0);
        check("mid_rst_restart", restart_pulse, 0);
        check("mid_rst_dir", cmd_if.cmd_dir, 0);
        exp_q.delete();
        step(1);
        reset = 1'b0;
        step(SETTLE);
        check("pending_discarded", fifo_count, 0);

        // Normal operation after reset
        press_turn(4'b1011, 1'b1, 1'b1);
        check("post_rst_count", fifo_count, 1);
        cmd_if.cmd_ready = 1'b1;
        step(1);
        cmd_if.cmd_ready = 1'b0;
        check("post_rst_pop", fifo_count, 0);
        check("final_sb_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
